mem_port_arbiter: RTL and testbench

Shares one single-port unified memory between the pipelined CPU's instruction-fetch port and its data-memory (load/store) port. Requests are accepted with a registered req/ack handshake, and each granted transaction runs on the memory bus with variable wait states. Data accesses normally have priority, bounded by a fetch-fairness counter, and a watchdog aborts hung transactions. The block sits between the IF and MEM pipeline stages and the memory model. The stall controller uses its pending/ack status to freeze the pipeline.

---
 rtl/mem_port_arbiter_if.sv | 49 ++++
 rtl/mem_port_arbiter.sv | 161 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_port_arbiter_if
//  Description : Bundle of the fetch port, data port, memory bus and status
//                signals of the unified-memory arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // Instruction-fetch port
    logic              iIfReq;
    logic [ADDR_W-1:0] iIfAddr;
    logic              oIfAck;
    logic [DATA_W-1:0] oIfData;
    // Data (load/store) port
    logic              iDReq;
    logic              iDWr;
    logic [ADDR_W-1:0] iDAddr;
    logic [DATA_W-1:0] iDWrData;
    logic              oDAck;
    logic [DATA_W-1:0] oDRdData;
    logic              oErr;
    // Memory bus
    logic              oMemReq;
    logic              oMemWr;
    logic [ADDR_W-1:0] oMemAddr;
    logic [DATA_W-1:0] oMemWrData;
    logic              iMemAck;
    logic [DATA_W-1:0] iMemRdData;
    // Status
    logic              oBusy;

    // Arbiter view
    modport slave (
        input  iIfReq, iIfAddr, iDReq, iDWr, iDAddr, iDWrData, iMemAck, iMemRdData,
        output oIfAck, oIfData, oDAck, oDRdData, oErr,
        output oMemReq, oMemWr, oMemAddr, oMemWrData, oBusy
    );

    // Requesters and memory model view
    modport master (
        output iIfReq, iIfAddr, iDReq, iDWr, iDAddr, iDWrData, iMemAck, iMemRdData,
        input  oIfAck, oIfData, oDAck, oDRdData, oErr,
        input  oMemReq, oMemWr, oMemAddr, oMemWrData, oBusy
    );
endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_port_arbiter
//  Description : Shares one single-port memory between the fetch port and
//                the data port. Data has priority, limited by a streak
//                counter so fetches are not starved; a watchdog aborts
//                transactions the memory never acknowledges.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int MAX_D_STREAK = 2,
    parameter int TIMEOUT_CYC  = 255
) (
    input  wire logic        clk,
    input  wire logic        reset,
    mem_port_arbiter_if.slave bus
);

    localparam int                  c_WAIT_W     = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [c_WAIT_W-1:0] c_TIMEOUT    = c_WAIT_W'(TIMEOUT_CYC);
    localparam logic [3:0]          c_MAX_STREAK = 4'(MAX_D_STREAK);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUS  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t              state_q,       state_d;
    logic                owner_q,       owner_d;      // 0 = fetch, 1 = data
    logic                mem_req_q,     mem_req_d;
    logic                mem_wr_q,      mem_wr_d;
    logic [ADDR_W-1:0]   mem_addr_q,    mem_addr_d;
    logic [DATA_W-1:0]   mem_wr_data_q, mem_wr_data_d;
    logic [c_WAIT_W-1:0] wait_cnt_q,    wait_cnt_d;
    logic [3:0]          d_streak_q,    d_streak_d;
    logic [DATA_W-1:0]   if_data_q,     if_data_d;
    logic [DATA_W-1:0]   d_rd_data_q,   d_rd_data_d;
    logic                err_armed_q,   err_armed_d;
    logic                w_grant_data;

    // Next-state logic: arbitration in IDLE, wait/timeout tracking in BUS
    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        mem_req_d     = mem_req_q;
        mem_wr_d      = mem_wr_q;
        mem_addr_d    = mem_addr_q;
        mem_wr_data_d = mem_wr_data_q;
        wait_cnt_d    = wait_cnt_q;
        d_streak_d    = d_streak_q;
        if_data_d     = if_data_q;
        d_rd_data_d   = d_rd_data_q;
        err_armed_d   = err_armed_q;
        w_grant_data  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.iIfReq || bus.iDReq) begin
                    // Data wins unless it has already taken its allowed streak
                    w_grant_data = bus.iDReq && (!bus.iIfReq || (d_streak_q < c_MAX_STREAK));
                    owner_d      = w_grant_data;
                    state_d      = S_BUS;
                    mem_req_d    = 1'b1;
                    wait_cnt_d   = '0;
                    err_armed_d  = 1'b0;
                    if (w_grant_data) begin
                        mem_addr_d    = bus.iDAddr;
                        mem_wr_d      = bus.iDWr;
                        mem_wr_data_d = bus.iDWrData;
                        if (!bus.iIfReq) begin
                            d_streak_d = 4'd0;
                        end else if (d_streak_q >= c_MAX_STREAK) begin
                            d_streak_d = c_MAX_STREAK;
                        end else begin
                            d_streak_d = d_streak_q + 4'd1;
                        end
                    end else begin
                        mem_addr_d = bus.iIfAddr;
                        mem_wr_d   = 1'b0;
                        d_streak_d = 4'd0;
                    end
                end
            end
            S_BUS: begin
                if (bus.iMemAck) begin
                    mem_req_d = 1'b0;
                    state_d   = S_RESP;
                    if (owner_q) begin
                        d_rd_data_d = mem_wr_q ? '0 : bus.iMemRdData;
                    end else begin
                        if_data_d = bus.iMemRdData;
                    end
                end else if ((TIMEOUT_CYC != 0) && (wait_cnt_q == c_TIMEOUT)) begin
                    // Memory never answered: complete with zero data and an error
                    mem_req_d   = 1'b0;
                    err_armed_d = 1'b1;
                    state_d     = S_RESP;
                    if (owner_q) begin
                        d_rd_data_d = '0;
                    end else begin
                        if_data_d = '0;
                    end
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State register with asynchronous reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            owner_q       <= 1'b0;
            mem_req_q     <= 1'b0;
            mem_wr_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wr_data_q <= '0;
            wait_cnt_q    <= '0;
            d_streak_q    <= 4'd0;
            if_data_q     <= '0;
            d_rd_data_q   <= '0;
            err_armed_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            mem_req_q     <= mem_req_d;
            mem_wr_q      <= mem_wr_d;
            mem_addr_q    <= mem_addr_d;
            mem_wr_data_q <= mem_wr_data_d;
            wait_cnt_q    <= wait_cnt_d;
            d_streak_q    <= d_streak_d;
            if_data_q     <= if_data_d;
            d_rd_data_q   <= d_rd_data_d;
            err_armed_q   <= err_armed_d;
        end
    end

    // Acks and error are decoded from registered state only
    assign bus.oIfAck     = (state_q == S_RESP) && !owner_q;
    assign bus.oDAck      = (state_q == S_RESP) &&  owner_q;
    assign bus.oErr       = (state_q == S_RESP) &&  err_armed_q;
    assign bus.oIfData    = if_data_q;
    assign bus.oDRdData   = d_rd_data_q;
    assign bus.oMemReq    = mem_req_q;
    assign bus.oMemWr     = mem_wr_q;
    assign bus.oMemAddr   = mem_addr_q;
    assign bus.oMemWrData = mem_wr_data_q;
    assign bus.oBusy      = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_port_arbiter
//  Description : Self-checking bench for mem_port_arbiter with directed
//                scenarios followed by randomized request traffic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int MAXS = 2;
    localparam int TOUT = 8;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_port_arbiter #(
        .ADDR_W      (AW),
        .DATA_W      (DW),
        .MAX_D_STREAK(MAXS),
        .TIMEOUT_CYC (TOUT)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: pending requests, streak count, last delivered data
    bit          if_pend = 1'b0;
    bit          d_pend  = 1'b0;
    logic [AW-1:0] if_addr = '0;
    logic [AW-1:0] d_addr  = '0;
    logic [DW-1:0] d_wdata = '0;
    bit          d_wr    = 1'b0;
    int          streak_m = 0;
    logic [DW-1:0] if_data_m = '0;
    logic [DW-1:0] d_data_m  = '0;
    bit          allow_raise = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic new_if(input logic [AW-1:0] a);
        if_pend     = 1'b1;
        if_addr     = a;
        bus.iIfReq  = 1'b1;
        bus.iIfAddr = a;
    endtask

    task automatic new_d(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] wd);
        d_pend       = 1'b1;
        d_wr         = wr;
        d_addr       = a;
        d_wdata      = wd;
        bus.iDReq    = 1'b1;
        bus.iDWr     = wr;
        bus.iDAddr   = a;
        bus.iDWrData = wd;
    endtask

    // One cycle with no request: arbiter must stay idle and ignore iMemAck
    task automatic idle_cycle();
        bus.iMemAck    = 1'($urandom_range(0, 1));
        bus.iMemRdData = $urandom;
        @(negedge clk);
        chk("idle_busy",   64'(bus.oBusy),   64'd0);
        chk("idle_memreq", 64'(bus.oMemReq), 64'd0);
        chk("idle_ack",    64'(bus.oIfAck | bus.oDAck), 64'd0);
        @(posedge clk); #1;
    endtask

    // Full transaction starting in an IDLE cycle with at least one request
    task automatic do_txn(input int w, input bit hang, input logic [DW-1:0] rdv, output bit owner);
        logic [AW-1:0] ea;
        bit            ewr;
        logic [DW-1:0] ewd;
        logic [DW-1:0] edata;
        int            last;
        owner = d_pend && (!if_pend || (streak_m < MAXS));
        if (owner) begin
            ea  = d_addr;
            ewr = d_wr;
            ewd = d_wdata;
            streak_m = if_pend ? ((streak_m + 1 > MAXS) ? MAXS : streak_m + 1) : 0;
        end else begin
            ea  = if_addr;
            ewr = 1'b0;
            ewd = '0;
            streak_m = 0;
        end
        // cycle 0: request seen in IDLE
        bus.iMemAck    = 1'($urandom_range(0, 1));
        bus.iMemRdData = $urandom;
        @(negedge clk);
        chk("c0_busy",   64'(bus.oBusy),   64'd0);
        chk("c0_memreq", 64'(bus.oMemReq), 64'd0);
        @(posedge clk); #1;
        // BUS cycles 1 .. 1+w (or 1+TOUT when the memory never answers)
        last = hang ? (1 + TOUT) : (1 + w);
        for (int c = 1; c <= last; c++) begin
            bus.iMemAck    = (!hang && (c == last));
            bus.iMemRdData = (!hang && (c == last)) ? rdv : DW'($urandom);
            if (c > 1) begin
                if (owner) bus.iDAddr = $urandom;
                else       bus.iIfAddr = $urandom;
            end
            if (allow_raise && owner && !if_pend && ($urandom_range(0, 2) == 0))
                new_if($urandom);
            if (allow_raise && !owner && !d_pend && ($urandom_range(0, 2) == 0))
                new_d(1'($urandom_range(0, 1)), $urandom, $urandom);
            @(negedge clk);
            chk("bus_memreq", 64'(bus.oMemReq), 64'd1);
            chk("bus_addr",   64'(bus.oMemAddr), 64'(ea));
            chk("bus_wr",     64'(bus.oMemWr),   64'(ewr));
            if (owner) chk("bus_wdata", 64'(bus.oMemWrData), 64'(ewd));
            chk("bus_busy",   64'(bus.oBusy), 64'd1);
            chk("bus_acks",   64'(bus.oIfAck | bus.oDAck), 64'd0);
            @(posedge clk); #1;
        end
        // RESP cycle: one-cycle ack from the owner
        bus.iMemAck    = 1'($urandom_range(0, 1));
        bus.iMemRdData = $urandom;
        edata = hang ? '0 : ((owner && ewr) ? '0 : rdv);
        @(negedge clk);
        chk("resp_ifack",  64'(bus.oIfAck),  64'(!owner));
        chk("resp_dack",   64'(bus.oDAck),   64'(owner));
        chk("resp_err",    64'(bus.oErr),    64'(hang));
        chk("resp_memreq", 64'(bus.oMemReq), 64'd0);
        chk("resp_busy",   64'(bus.oBusy),   64'd1);
        chk("resp_addr",   64'(bus.oMemAddr), 64'(ea));
        if (owner) begin
            chk("resp_drd",    64'(bus.oDRdData), 64'(edata));
            chk("hold_ifdata", 64'(bus.oIfData),  64'(if_data_m));
            d_data_m = edata;
        end else begin
            chk("resp_ifdata", 64'(bus.oIfData),  64'(edata));
            chk("hold_drd",    64'(bus.oDRdData), 64'(d_data_m));
            if_data_m = edata;
        end
        @(posedge clk); #1;
        // requester saw the ack and drops its request
        if (owner) begin
            d_pend = 1'b0;
            bus.iDReq = 1'b0;
        end else begin
            if_pend = 1'b0;
            bus.iIfReq = 1'b0;
        end
        bus.iMemAck = 1'b0;
    endtask

    initial begin
        bit own;
        int w;
        bit hang;

        reset          = 1'b1;
        bus.iIfReq     = 1'b0;
        bus.iIfAddr    = '0;
        bus.iDReq      = 1'b0;
        bus.iDWr       = 1'b0;
        bus.iDAddr     = '0;
        bus.iDWrData   = '0;
        bus.iMemAck    = 1'b0;
        bus.iMemRdData = '0;
        #3;
        chk("rst_memreq", 64'(bus.oMemReq),    64'd0);
        chk("rst_memwr",  64'(bus.oMemWr),     64'd0);
        chk("rst_busy",   64'(bus.oBusy),      64'd0);
        chk("rst_acks",   64'({bus.oIfAck, bus.oDAck, bus.oErr}), 64'd0);
        chk("rst_addr",   64'(bus.oMemAddr),   64'd0);
        chk("rst_wdata",  64'(bus.oMemWrData), 64'd0);
        chk("rst_ifdata", 64'(bus.oIfData),    64'd0);
        chk("rst_drd",    64'(bus.oDRdData),   64'd0);
        chk("rst_streak", 64'(dut.d_streak_q), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        idle_cycle();

        // Zero-wait fetch
        new_if(32'h10);
        do_txn(0, 1'b0, 32'h8C22_0004, own);
        chk("t1_owner_is_fetch", 64'(bus.oIfData), 64'h8C22_0004);

        // Simultaneous requests: store first, then fetch
        new_if(32'h44);
        new_d(1'b1, 32'h40, 32'hDEAD_BEEF);
        do_txn(0, 1'b0, $urandom, own);
        do_txn(1, 1'b0, $urandom, own);

        // Streak limit with continuous requests on both ports
        new_if(32'h100);
        new_d(1'b0, 32'h200, 32'h0);
        for (int k = 0; k < 6; k++) begin
            do_txn(k % 2, 1'b0, $urandom, own);
            if (k < 5) begin
                if (own) new_d(1'b0, 32'h204 + 32'(4 * k), 32'h0);
                else     new_if(32'h104 + 32'(4 * k));
            end
        end
        do_txn(0, 1'b0, $urandom, own);

        // Load with three wait states
        new_d(1'b0, 32'h20, 32'h0);
        do_txn(3, 1'b0, 32'h5, own);

        // Watchdog abort, then a normal transaction
        new_d(1'b0, 32'h30, 32'h0);
        do_txn(0, 1'b1, 32'h0, own);
        new_if(32'h34);
        do_txn(1, 1'b0, $urandom, own);

        // Reset during the second wait cycle of a fetch
        new_if(32'h50);
        bus.iMemAck = 1'b0;
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        chk("prerst_memreq", 64'(bus.oMemReq), 64'd1);
        @(posedge clk); #1;
        #2;
        reset = 1'b1;
        #1;
        chk("midrst_memreq", 64'(bus.oMemReq),    64'd0);
        chk("midrst_busy",   64'(bus.oBusy),      64'd0);
        chk("midrst_streak", 64'(dut.d_streak_q), 64'd0);
        chk("midrst_ifack",  64'(bus.oIfAck),     64'd0);
        bus.iIfReq = 1'b0;
        if_pend    = 1'b0;
        d_pend     = 1'b0;
        streak_m   = 0;
        if_data_m  = '0;
        d_data_m   = '0;
        @(posedge clk); #1;
        reset = 1'b0;
        idle_cycle();
        idle_cycle();
        new_if(32'h54);
        do_txn(0, 1'b0, $urandom, own);

        // Randomized traffic
        allow_raise = 1'b1;
        for (int n = 0; n < 80; n++) begin
            if (!if_pend && ($urandom_range(0, 1) == 1)) new_if($urandom);
            if (!d_pend && ($urandom_range(0, 1) == 1))
                new_d(1'($urandom_range(0, 1)), $urandom, $urandom);
            if (!if_pend && !d_pend) begin
                idle_cycle();
            end else begin
                w    = $urandom_range(0, 4);
                hang = ($urandom_range(0, 7) == 0);
                do_txn(w, hang, $urandom, own);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Guard against a stuck simulation
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d", checks);
        $fatal(1, "time limit");
    end

endmodule
`default_nettype wire
